// File: rtl/regfile_scoreboard.sv
// Issue-side register scoreboard: per-register saturating pending-write
// counters, RAW/saturation stall generation with same-cycle write-back bypass.

// One tracked register: pending counter plus its release/bypass view.
module regfile_scoreboard_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             rel,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic [CNT_W-1:0] eff,
  output logic             uflow
);
  logic dec;

  assign dec   = rel & (cnt != '0);
  // A release this cycle is already visible to readers (negedge RF write).
  assign eff   = dec ? cnt - CNT_W'(1) : cnt;
  assign uflow = rel & (cnt == '0) & ~inc;

  // Net counter change; issue and release in the same cycle cancel out.
  always_comb begin
    cnt_nxt = cnt;
    if (inc & ~dec)      cnt_nxt = cnt + CNT_W'(1);
    else if (dec & ~inc) cnt_nxt = cnt - CNT_W'(1);
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
endmodule

module regfile_scoreboard #(
  parameter int NREG  = 15,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [3:0]      src1,
  input  logic [3:0]      src2,
  input  logic            src1_en,
  input  logic            src2_en,
  input  logic            dest_en,
  input  logic [3:0]      dest,
  input  logic            write_back_en,
  input  logic [3:0]      dest_wb,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] busy_mask,
  output logic [5:0]      pending_total,
  output logic            sb_err
);
  localparam logic [3:0]       NREG4 = 4'(NREG);
  localparam logic [CNT_W-1:0] CMAX  = {CNT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt, cnt_nxt, eff;
  logic [NREG-1:0]            uflow;
  logic [15:0][CNT_W-1:0]     eff_ext;  // padded so any 4-bit index is legal
  logic                       h1, h2, hs;
  logic [5:0]                 total_nxt;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic inc_i, rel_i;
    assign inc_i = issue_fire & dest_en & (dest == 4'(i));
    assign rel_i = write_back_en & (dest_wb == 4'(i));
    regfile_scoreboard_cell #(.CNT_W(CNT_W)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_i),
      .rel     (rel_i),
      .cnt     (cnt[i]),
      .cnt_nxt (cnt_nxt[i]),
      .eff     (eff[i]),
      .uflow   (uflow[i])
    );
    assign busy_mask[i] = |cnt[i];
  end

  for (genvar i = 0; i < 16; i++) begin : g_pad
    if (i < NREG) begin : g_live
      assign eff_ext[i] = eff[i];
    end else begin : g_zero
      assign eff_ext[i] = '0;
    end
  end

  // Hazard detection; index 15 (PC) and anything past NREG never hazards.
  always_comb begin
    h1         = src1_en & (src1 < NREG4) & (eff_ext[src1] != '0);
    h2         = src2_en & (src2 < NREG4) & (eff_ext[src2] != '0);
    hs         = dest_en & (dest < NREG4) & (eff_ext[dest] == CMAX);
    stall      = issue_valid & (h1 | h2 | hs);
    issue_fire = issue_valid & ~stall;
  end

  // Post-update sum of all counters.
  always_comb begin
    total_nxt = '0;
    for (int i = 0; i < NREG; i++) total_nxt = total_nxt + 6'(cnt_nxt[i]);
  end

  // Registered total and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_total <= '0;
      sb_err        <= 1'b0;
    end else begin
      pending_total <= total_nxt;
      sb_err        <= sb_err | (|uflow);
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, async reset check,
// then randomized traffic against an array-of-counts reference model.
module tb_regfile_scoreboard;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        issue_valid = 0, src1_en = 0, src2_en = 0, dest_en = 0, write_back_en = 0;
  logic [3:0]  src1 = 0, src2 = 0, dest = 0, dest_wb = 0;
  logic        stall, issue_fire, sb_err;
  logic [14:0] busy_mask;
  logic [5:0]  pending_total;

  int checks = 0, failures = 0;
  int mcnt[15];
  bit merr;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .src1(src1), .src2(src2), .src1_en(src1_en), .src2_en(src2_en),
    .dest_en(dest_en), .dest(dest), .write_back_en(write_back_en), .dest_wb(dest_wb),
    .stall(stall), .issue_fire(issue_fire), .busy_mask(busy_mask),
    .pending_total(pending_total), .sb_err(sb_err)
  );

  typedef struct {
    logic v; logic [3:0] s1; logic s1e; logic [3:0] s2; logic s2e;
    logic de; logic [3:0] d; logic we; logic [3:0] wb;
    logic st; logic [14:0] busy; logic [5:0] pend; logic err;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic v, logic [3:0] s1, logic s1e, logic [3:0] s2, logic s2e,
                              logic de, logic [3:0] d, logic we, logic [3:0] wb,
                              logic st, logic [14:0] busy, logic [5:0] pend, logic err);
    vec_t r;
    r.v = v; r.s1 = s1; r.s1e = s1e; r.s2 = s2; r.s2e = s2e;
    r.de = de; r.d = d; r.we = we; r.wb = wb;
    r.st = st; r.busy = busy; r.pend = pend; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic s1e, input logic [3:0] s2,
                       input logic s2e, input logic de, input logic [3:0] d, input logic we,
                       input logic [3:0] wb);
    issue_valid = v; src1 = s1; src1_en = s1e; src2 = s2; src2_en = s2e;
    dest_en = de; dest = d; write_back_en = we; dest_wb = wb;
  endtask

  // ---- reference model: pending writes per register as plain integers ----
  function automatic int m_eff(int r);
    int e;
    if (r > 14) return 0;
    e = mcnt[r] - ((write_back_en && int'(dest_wb) == r) ? 1 : 0);
    return (e < 0) ? 0 : e;
  endfunction

  function automatic bit m_stall();
    bit h;
    h = (src1_en && m_eff(int'(src1)) > 0) || (src2_en && m_eff(int'(src2)) > 0) ||
        (dest_en && dest != 4'd15 && m_eff(int'(dest)) == 3);
    return issue_valid && h;
  endfunction

  function automatic logic [14:0] m_busy();
    logic [14:0] b;
    for (int r = 0; r < 15; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  function automatic int m_pend();
    int s = 0;
    for (int r = 0; r < 15; r++) s += mcnt[r];
    return s;
  endfunction

  task automatic m_step();
    bit fire, inc, rl;
    fire = issue_valid && !m_stall();
    for (int r = 0; r < 15; r++) begin
      inc = fire && dest_en && int'(dest) == r;
      rl  = write_back_en && int'(dest_wb) == r;
      if (rl && mcnt[r] == 0 && !inc) merr = 1;
      mcnt[r] = mcnt[r] + (inc ? 1 : 0) - ((rl && mcnt[r] > 0) ? 1 : 0);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < 15; r++) mcnt[r] = 0;
    merr = 0;
  endtask

  function automatic logic [3:0] pick();
    int k = $urandom_range(0, 6);
    return (k == 6) ? 4'd15 : 4'(k);
  endfunction

  initial begin
    // RAW on R3, release at cycle 4
    tbl[0]  = mk(1, 0,0, 0,0, 1,3, 0,0,  0, 15'h000, 0, 0);
    tbl[1]  = mk(1, 3,1, 0,0, 0,0, 0,0,  1, 15'h008, 1, 0);
    tbl[2]  = mk(1, 3,1, 0,0, 0,0, 0,0,  1, 15'h008, 1, 0);
    tbl[3]  = mk(1, 3,1, 0,0, 0,0, 0,0,  1, 15'h008, 1, 0);
    tbl[4]  = mk(1, 3,1, 0,0, 0,0, 1,3,  0, 15'h008, 1, 0);
    tbl[5]  = mk(0, 0,0, 0,0, 0,0, 0,0,  0, 15'h000, 0, 0);
    // saturation of R5
    tbl[6]  = mk(1, 0,0, 0,0, 1,5, 0,0,  0, 15'h000, 0, 0);
    tbl[7]  = mk(1, 0,0, 0,0, 1,5, 0,0,  0, 15'h020, 1, 0);
    tbl[8]  = mk(1, 0,0, 0,0, 1,5, 0,0,  0, 15'h020, 2, 0);
    tbl[9]  = mk(1, 0,0, 0,0, 1,5, 0,0,  1, 15'h020, 3, 0);
    tbl[10] = mk(1, 0,0, 0,0, 1,5, 1,5,  0, 15'h020, 3, 0);
    tbl[11] = mk(0, 0,0, 0,0, 0,0, 0,0,  0, 15'h020, 3, 0);
    // simultaneous inc/dec on R7
    tbl[12] = mk(1, 0,0, 0,0, 1,7, 0,0,  0, 15'h020, 3, 0);
    tbl[13] = mk(1, 0,0, 0,0, 1,7, 1,7,  0, 15'h0A0, 4, 0);
    tbl[14] = mk(0, 0,0, 0,0, 0,0, 0,0,  0, 15'h0A0, 4, 0);
    // R15 is invisible
    tbl[15] = mk(1, 15,1, 15,1, 1,15, 1,15, 0, 15'h0A0, 4, 0);
    tbl[16] = mk(0, 0,0, 0,0, 0,0, 0,0,  0, 15'h0A0, 4, 0);
    // underflow on R2, sticky
    tbl[17] = mk(0, 0,0, 0,0, 0,0, 1,2,  0, 15'h0A0, 4, 0);
    tbl[18] = mk(0, 0,0, 0,0, 0,0, 0,0,  0, 15'h0A0, 4, 1);
    tbl[19] = mk(0, 0,0, 0,0, 0,0, 0,0,  0, 15'h0A0, 4, 1);
    // src2 hazard, and no stall without issue_valid
    tbl[20] = mk(1, 0,0, 7,1, 0,0, 0,0,  1, 15'h0A0, 4, 1);
    tbl[21] = mk(0, 5,1, 0,0, 1,5, 0,0,  0, 15'h0A0, 4, 1);

    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy_mask), 0);
    chk("reset_pend", 32'(pending_total), 0);
    chk("reset_err", 32'(sb_err), 0);
    chk("reset_stall", 32'(stall), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].v, tbl[i].s1, tbl[i].s1e, tbl[i].s2, tbl[i].s2e,
            tbl[i].de, tbl[i].d, tbl[i].we, tbl[i].wb);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_fire", i), 32'(issue_fire), 32'(tbl[i].v & ~tbl[i].st));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_mask), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_pend", i), 32'(pending_total), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_err", i), 32'(sb_err), 32'(tbl[i].err));
    end

    // mid-run asynchronous reset with live counters and sb_err set
    @(posedge clk); #1;
    drive(0, 0,0, 0,0, 0,0, 0,0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_mask), 0);
    chk("async_rst_pend", 32'(pending_total), 0);
    chk("async_rst_err", 32'(sb_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [3:0] wb;
      bit         we;
      int         start;
      @(posedge clk); #1;
      we = 0; wb = 0;
      if ($urandom_range(0, 19) == 0) begin
        we = 1; wb = pick();
      end else if ($urandom_range(0, 2) == 0) begin
        start = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++)
          if (!we && mcnt[(start + k) % 15] != 0) begin
            we = 1; wb = 4'((start + k) % 15);
          end
      end
      drive(1'($urandom_range(0, 3) != 0), pick(), 1'($urandom_range(0, 1)), pick(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), pick(), we, wb);
      @(negedge clk);
      chk("rnd_stall", 32'(stall), 32'(m_stall()));
      chk("rnd_fire", 32'(issue_fire), 32'(issue_valid && !m_stall()));
      chk("rnd_busy", 32'(busy_mask), 32'(m_busy()));
      chk("rnd_pend", 32'(pending_total), 32'(m_pend()));
      chk("rnd_err", 32'(sb_err), 32'(merr));
      m_step();
    end
    @(posedge clk); #1;
    drive(0, 0,0, 0,0, 0,0, 0,0);
    @(negedge clk);
    chk("final_busy", 32'(busy_mask), 32'(m_busy()));
    chk("final_pend", 32'(pending_total), 32'(m_pend()));
    chk("final_err", 32'(sb_err), 32'(merr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
